booth_pp_reducer: RTL and testbench
===================================

Name: booth_pp_reducer

Overview:
- Pipelined Wallace-tree reducer that consumes the eight 32-bit Booth partial products from the Booth encoding stage.
- Compresses them through 3:2 carry-save levels (8->6->4->3->2) and produces the final 32-bit signed product with a carry-propagate add.
- Sits between the Booth encoder and the multiplier result interface.
- Uses a valid/ready handshake with full backpressure and carries a sideband tag alongside each operation.

Parameters:
- W, 32, width of partial products, internal carry-save vectors and the product.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  partial-product set on pp1..pp8 is valid.
- in_ready  output  1  block accepts a set this cycle.
- in_tag  input  TAG_W  sideband tag accepted with the set.
- pp1 .. pp8  input  W each  partial products, already shifted and sign-extended, summed modulo 2^W.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- product  output  W  sum of pp1..pp8 modulo 2^W.
- out_tag  output  TAG_W  tag of the set that produced product.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following to 0:
  - all stage valid bits;
  - out_valid, product, out_tag;
  - all pipeline data registers.
- in_ready is combinational, so it reads 1 during reset.
- Release is synchronous to clk; the first accept is possible on the first edge with rst_n high.
- Pipeline has three register stages, S1 -> S2 -> S3. S3 drives product and out_tag.
  - S1 (combinational into the register): level 1 is CSA(pp1,pp2,pp3) and CSA(pp4,pp5,pp6), with pp7 and pp8 passed through, giving 6 vectors. Level 2 is two CSAs giving 4 vectors. S1 registers these 4 vectors, the tag and a valid bit.
  - S2: level 3 is a CSA on 3 of the vectors with the 4th passed through, giving 3 vectors. Level 4 is a CSA giving sum and carry. S2 registers sum, carry, tag and valid.
  - S3: carry-propagate add sum + carry, with the final carry-out discarded. S3 registers product, tag and valid.
- CSA rules:
  - s = a^b^c;
  - c = majority(a,b,c) shifted left by 1, with bit 0 = 0 and the carry out of bit W-1 discarded.
  - All arithmetic is modulo 2^W.
- Stall rule: global enable adv = !out_valid | out_ready. in_ready = adv.
  - When adv=1, all stages shift by one. Sx.valid takes the previous stage's valid; S1.valid takes in_valid.
  - When adv=0, every stage holds its data and valid.
- Accept: in_valid & in_ready. Latency is exactly 3 adv cycles from accept to out_valid. With out_ready held at 1, latency is 3 clk cycles.
- Throughput is one set per cycle when out_ready=1 continuously.
- Bubbles are not collapsed. A stall freezes bubbles in place, and in_ready=0 for as long as out_valid=1 and out_ready=0.
- Output stability: while out_valid=1 and out_ready=0, product and out_tag hold bit-stable.
- in_valid with in_ready=0: the input is not captured. The source must hold the set; the block does not check this.
- Simultaneous accept and output handshake in the same cycle is legal; both complete.
- Reset mid-operation discards all in-flight sets; no partial output appears after reset.
- There are no overflow flags. For 16x16 signed Booth products the 32-bit result is always exact, including -32768 * -32768 = 0x40000000.

Decomposition:
- Shared package mult_pkg holds:
  - localparams NUM_PP=8 and PROD_W=32;
  - the CSA level count;
  - a typedef for the carry-save pair {sum, carry} of PROD_W bits.
- Sub-module csa_3to2: parameterised W, purely combinational, instantiated six times.
- The final adder reuses the team's existing Kogge-Stone adder (KSA_top_level, cin=0, cout unused).

Test Plan:
- Bench drives pp1..pp8 from the Booth encoder outputs for M=3, Q=5; in_valid one cycle, out_ready=1 -> out_valid exactly 3 cycles later, product=0x0000000F, out_tag equal to in_tag.
- M=-32768, Q=-32768, then M=-1, Q=1, then M=32767, Q=-32768, back-to-back with out_ready=1 -> three consecutive out_valid cycles with products 0x40000000, 0xFFFFFFFF, 0xC0008000, in order.
- Fill pipeline with 3 sets with tags 1,2,3, then out_ready=0 for 5 cycles:
  - in_ready=0 throughout;
  - product and out_tag hold on tag 1;
  - on out_ready=1, tags 1,2,3 emerge on consecutive cycles.
- Assert rst_n=0 mid-stream with two sets in flight -> out_valid and product go to 0 immediately (asynchronously); after release, no stale result appears; the next accepted set (M=7, Q=-9) yields 0xFFFFFFC1.
- Randomised 10k M, Q pairs with random out_ready (50%) -> every product equals M*Q sign-extended to 32 bits, tags in order, no drops or duplicates.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath.
// Holds the partial-product count, the product width, the number of 3:2
// compression levels in the reducer tree and the carry-save pair type that
// is passed between reducer stages.
package mult_pkg;

  localparam int unsigned NUM_PP     = 8;
  localparam int unsigned PROD_W     = 32;
  // 8 -> 6 -> 4 -> 3 -> 2
  localparam int unsigned CSA_LEVELS = 4;

  typedef struct packed {
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] carry;
  } cs_pair_t;

endpackage

// File: rtl/booth_pp_reducer_if.sv
// Handshake bundle for booth_pp_reducer.
// Input side : in_valid/in_ready/in_tag plus the eight partial products pp1..pp8.
// Output side: out_valid/out_ready/product/out_tag.
// master : the environment (Booth encoder upstream, result interface downstream).
// slave  : the reducer itself.
interface booth_pp_reducer_if
  import mult_pkg::*;
#(
  parameter int unsigned W     = PROD_W,
  parameter int unsigned TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     pp1;
  logic [W-1:0]     pp2;
  logic [W-1:0]     pp3;
  logic [W-1:0]     pp4;
  logic [W-1:0]     pp5;
  logic [W-1:0]     pp6;
  logic [W-1:0]     pp7;
  logic [W-1:0]     pp8;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     product;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_tag, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, out_ready,
    input  in_ready, out_valid, product, out_tag
  );

  modport slave (
    input  in_valid, in_tag, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, out_ready,
    output in_ready, out_valid, product, out_tag
  );

endinterface

// File: rtl/KSA_top_level.sv
// Kogge-Stone parallel-prefix adder.
// Ports: a, b - W-bit addends
//        cin  - carry into bit 0
//        sum  - a + b + cin modulo 2^W
//        cout - carry out of bit W-1
module KSA_top_level #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned LVL = $clog2(W);

  // g[l][i]: group generate over bits max(0,i-2^l+1)..i (cin folded into bit 0)
  // p[l][i]: matching group propagate
  logic [LVL:0][W-1:0]   g;
  logic [LVL-1:0][W-1:0] p;

  always_comb begin
    g = '0;
    p = '0;
    g[0] = a & b;
    p[0] = a ^ b;
    g[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    for (int unsigned l = 0; l < LVL; l++) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (i >= (32'd1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][i - (32'd1 << l)]);
          if (l + 1 < LVL) p[l+1][i] = p[l][i] & p[l][i - (32'd1 << l)];
        end else begin
          g[l+1][i] = g[l][i];
          if (l + 1 < LVL) p[l+1][i] = p[l][i];
        end
      end
    end
  end

  // Carry into bit i is the group generate of bits 0..i-1.
  assign sum  = (a ^ b) ^ {g[LVL][W-2:0], cin};
  assign cout = g[LVL][W-1];

endmodule

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor, purely combinational.
// Ports: x, y, z - three W-bit addends
//        sum     - bitwise sum x^y^z
//        carry   - majority(x,y,z) shifted left by one; bit 0 is 0 and the
//                  carry out of bit W-1 is dropped (modulo 2^W)
module csa_3to2 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = x ^ y ^ z;
  // Only bits W-2..0 of the majority survive the shift.
  assign carry = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

// File: rtl/booth_pp_reducer.sv
// Three-stage Wallace-tree reducer for eight Booth partial products.
//   S1: CSA levels 1-2 (8 -> 6 -> 4), registers 4 vectors + tag + valid
//   S2: CSA levels 3-4 (4 -> 3 -> 2), registers sum/carry + tag + valid
//   S3: Kogge-Stone carry-propagate add, registers product + tag + valid
// Ports: clk, rst_n (async active-low)
//        bus (slave): in_valid/in_ready/in_tag/pp1..pp8 in,
//                     out_valid/out_ready/product/out_tag out
// All stages advance together whenever the output register is empty or being
// drained; otherwise everything (bubbles included) is frozen.
module booth_pp_reducer
  import mult_pkg::*;
#(
  parameter int unsigned W     = PROD_W,
  parameter int unsigned TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_pp_reducer_if.slave   bus
);

  localparam int unsigned S1_VECS = NUM_PP / 2;

  logic adv;

  // Stage registers
  logic                       s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]           s1_tag_q,   s1_tag_d;
  logic [S1_VECS-1:0][W-1:0]  s1_vec_q,   s1_vec_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0]           s2_tag_q,   s2_tag_d;
  cs_pair_t                   s2_cs_q,    s2_cs_d;
  logic                       out_valid_q, out_valid_d;
  logic [TAG_W-1:0]           out_tag_q,   out_tag_d;
  logic [W-1:0]               product_q,   product_d;

  // Tree nets
  logic [W-1:0] l1_s0, l1_c0, l1_s1, l1_c1;
  logic [W-1:0] l2_s0, l2_c0, l2_s1, l2_c1;
  logic [W-1:0] l3_s, l3_c;
  logic [W-1:0] l4_s, l4_c;
  logic [W-1:0] cpa_sum;
  logic         ksa_cout_unused;

  assign adv          = !out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  // Level 1: two CSAs, pp7/pp8 pass through
  csa_3to2 #(.W(W)) u_l1a (.x(bus.pp1), .y(bus.pp2), .z(bus.pp3), .sum(l1_s0), .carry(l1_c0));
  csa_3to2 #(.W(W)) u_l1b (.x(bus.pp4), .y(bus.pp5), .z(bus.pp6), .sum(l1_s1), .carry(l1_c1));

  // Level 2: 6 -> 4
  csa_3to2 #(.W(W)) u_l2a (.x(l1_s0), .y(l1_c0), .z(l1_s1), .sum(l2_s0), .carry(l2_c0));
  csa_3to2 #(.W(W)) u_l2b (.x(l1_c1), .y(bus.pp7), .z(bus.pp8), .sum(l2_s1), .carry(l2_c1));

  // Level 3: 4 -> 3, vector 3 passes through
  csa_3to2 #(.W(W)) u_l3 (.x(s1_vec_q[0]), .y(s1_vec_q[1]), .z(s1_vec_q[2]), .sum(l3_s), .carry(l3_c));

  // Level 4: 3 -> 2
  csa_3to2 #(.W(W)) u_l4 (.x(l3_s), .y(l3_c), .z(s1_vec_q[3]), .sum(l4_s), .carry(l4_c));

  KSA_top_level #(.W(W)) u_cpa (
    .a    (s2_cs_q.sum),
    .b    (s2_cs_q.carry),
    .cin  (1'b0),
    .sum  (cpa_sum),
    .cout (ksa_cout_unused)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_tag_d    = s1_tag_q;
    s1_vec_d    = s1_vec_q;
    s2_valid_d  = s2_valid_q;
    s2_tag_d    = s2_tag_q;
    s2_cs_d     = s2_cs_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    product_d   = product_q;
    if (adv) begin
      // Data registers load unconditionally; only the valid bits qualify them.
      s1_valid_d    = bus.in_valid;
      s1_tag_d      = bus.in_tag;
      s1_vec_d      = {l2_c1, l2_s1, l2_c0, l2_s0};
      s2_valid_d    = s1_valid_q;
      s2_tag_d      = s1_tag_q;
      s2_cs_d.sum   = l4_s;
      s2_cs_d.carry = l4_c;
      out_valid_d   = s2_valid_q;
      out_tag_d     = s2_tag_q;
      product_d     = cpa_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_vec_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      s2_cs_q     <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      product_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_vec_q    <= s1_vec_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      s2_cs_q     <= s2_cs_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      product_q   <= product_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_booth_pp_reducer.sv
// Self-checking bench for booth_pp_reducer: directed Booth vectors, stall,
// reset and a random phase, with a product = M*Q scoreboard.
module tb_booth_pp_reducer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  booth_pp_reducer_if #(.W(32), .TAG_W(4)) bus ();

  booth_pp_reducer #(.W(32), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  tag;
  } exp_t;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  exp_t exp_q[$];
  logic signed [15:0] cur_m = '0;
  logic signed [15:0] cur_q = '0;
  logic rand_mode = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_prod = '0;
  logic [3:0]  prev_tag = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: the signed 16x16 product, 32 bits.
  function automatic logic [31:0] model(input logic signed [15:0] m, input logic signed [15:0] q);
    int mi;
    int qi;
    mi = m;
    qi = q;
    return 32'(mi * qi);
  endfunction

  // Radix-4 Booth encoder: eight shifted, sign-extended partial products.
  function automatic logic [7:0][31:0] booth_pps(input logic signed [15:0] m, input logic [15:0] q);
    logic [7:0][31:0] r;
    logic [16:0] qe;
    logic [2:0] trip;
    int d;
    qe = {q, 1'b0};
    for (int j = 0; j < 8; j++) begin
      trip = qe[2*j+2 -: 3];
      case (trip)
        3'b001, 3'b010: d = 1;
        3'b011:         d = 2;
        3'b100:         d = -2;
        3'b101, 3'b110: d = -1;
        default:        d = 0;
      endcase
      r[j] = 32'(d * int'(m)) << (2 * j);
    end
    return r;
  endfunction

  task automatic drive_set(input logic signed [15:0] m, input logic signed [15:0] q, input logic [3:0] tag);
    logic [7:0][31:0] pps;
    int unsigned n;
    pps = booth_pps(m, q);
    bus.pp1 = pps[0]; bus.pp2 = pps[1]; bus.pp3 = pps[2]; bus.pp4 = pps[3];
    bus.pp5 = pps[4]; bus.pp6 = pps[5]; bus.pp7 = pps[6]; bus.pp8 = pps[7];
    bus.in_tag = tag;
    cur_m = m;
    cur_q = q;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 1000);
    if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name);
    int unsigned n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) check(name, 32'(bus.out_valid), 32'd1);
  endtask

  // Per-cycle compare process: scoreboard, stall stability, in_ready rule.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_product", bus.product, prev_prod);
        check("stall_tag", 32'(bus.out_tag), 32'(prev_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL out_spurious: product %h tag %h with nothing pending at %0t",
                   bus.product, bus.out_tag, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_product", bus.product, e.prod);
          check("sb_tag", 32'(bus.out_tag), 32'(e.tag));
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back('{model(cur_m, cur_q), bus.in_tag});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_prod  = bus.product;
      prev_tag   = bus.out_tag;
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][31:0] pps;
    logic [31:0] acc;
    int unsigned n;

    bus.in_valid = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
    bus.pp1 = '0; bus.pp2 = '0; bus.pp3 = '0; bus.pp4 = '0;
    bus.pp5 = '0; bus.pp6 = '0; bus.pp7 = '0; bus.pp8 = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product", bus.product, 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin stimulus generator and model
    pps = booth_pps(16'sd3, 16'sd5);
    acc = '0;
    for (int j = 0; j < 8; j++) acc += pps[j];
    check("booth_sum_3x5", acc, 32'h0000000F);
    check("model_min_x_min", model(-16'sd32768, -16'sd32768), 32'h40000000);
    check("model_7x_m9", model(16'sd7, -16'sd9), 32'hFFFFFFC1);

    // Single set, latency 3
    @(posedge clk); #1;
    drive_set(16'sd3, 16'sd5, 4'hA);
    bus.in_valid = 1'b0;
    @(negedge clk); check("lat_c1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check("lat_c2_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check("lat_c3_valid", 32'(bus.out_valid), 32'd1);
    check("lat_product", bus.product, 32'h0000000F);
    check("lat_tag", 32'(bus.out_tag), 32'hA);

    // Back-to-back corner products
    repeat (3) @(posedge clk); #1;
    drive_set(-16'sd32768, -16'sd32768, 4'h1);
    drive_set(-16'sd1, 16'sd1, 4'h2);
    drive_set(16'sd32767, -16'sd32768, 4'h3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    wait_out_valid("b2b_wait");
    check("b2b_p0", bus.product, 32'h40000000);
    @(negedge clk); check("b2b_v1", 32'(bus.out_valid), 32'd1);
    check("b2b_p1", bus.product, 32'hFFFFFFFF);
    @(negedge clk); check("b2b_v2", 32'(bus.out_valid), 32'd1);
    check("b2b_p2", bus.product, 32'hC0008000);

    // Fill with tags 1..3, then stall for 5 cycles
    repeat (4) @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive_set(16'sd100, -16'sd3, 4'h1);
    drive_set(-16'sd7, -16'sd7, 4'h2);
    drive_set(16'sd1234, 16'sd56, 4'h3);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_tag1", 32'(bus.out_tag), 32'h1);
      check("stall_prod1", bus.product, 32'hFFFFFED4);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk); check("drain_tag1", 32'(bus.out_tag), 32'h1);
    @(negedge clk); check("drain_tag2", 32'(bus.out_tag), 32'h2);
    check("drain_prod2", bus.product, 32'h00000031);
    @(negedge clk); check("drain_tag3", 32'(bus.out_tag), 32'h3);
    check("drain_prod3", bus.product, 32'h00010DF0);

    // Reset with sets in flight
    repeat (4) @(posedge clk); #1;
    drive_set(16'sd11, 16'sd13, 4'h5);
    drive_set(-16'sd2, 16'sd9, 4'h6);
    drive_set(16'sd4, 16'sd4, 4'h7);
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_product", bus.product, 32'd0);
    check("arst_out_tag", 32'(bus.out_tag), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    drive_set(16'sd7, -16'sd9, 4'h9);
    bus.in_valid = 1'b0;
    @(negedge clk);
    wait_out_valid("post_rst_wait");
    check("post_rst_product", bus.product, 32'hFFFFFFC1);
    check("post_rst_tag", 32'(bus.out_tag), 32'h9);

    // Random phase
    repeat (3) @(posedge clk); #1;
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      drive_set(16'($urandom), 16'($urandom), 4'(i));
    end
    bus.in_valid = 1'b0;
    rand_mode = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
